// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serial audio transmitter with MCLK/BCLK/frame-clock generation and a one-frame holding buffer.
// Optional macro I2S_UNDERRUN_MUTE_EN: an underrun frame is sent as silence instead of repeating the last frame.
module i2s_tdm_tx #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SLOT_W   = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MCK_HALF = 1,
  parameter int unsigned SCK_HALF = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         mck,
  output logic                         sck,
  output logic                         lr,
  output logic                         d,
  output logic                         frame_stb,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int unsigned N  = CHANNELS * SLOT_W;
  localparam int unsigned IW = CHANNELS * DATA_W;
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned MW = $clog2(MCK_HALF + 1);
  localparam int unsigned SW = $clog2(SCK_HALF + 1);
  localparam logic [MW-1:0] MCK_LAST = MW'(MCK_HALF - 1);
  localparam logic [SW-1:0] SCK_LAST = SW'(SCK_HALF - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(N - 1);
  localparam logic [PW-1:0] P_SLOT   = PW'(SLOT_W);
  localparam bit            STEREO   = (CHANNELS == 2);

  logic [MW-1:0] mck_cnt;
  logic [SW-1:0] sck_cnt;
  logic [PW-1:0] p;
  logic [PW-1:0] p_next;
  logic          started;
  logic [N-1:0]  sr;
  logic [N-1:0]  frame;
  logic [IW-1:0] buf_dat;
  logic [IW-1:0] last_dat;
  logic [IW-1:0] src;
  logic          buf_full;
  logic          fall;
  logic          load;
  logic          take;
  logic          lr_next;

  assign in_ready = ~buf_full;
  assign take     = in_valid & ~buf_full;
  assign fall     = enable & sck & (sck_cnt == SCK_LAST);
  // 'started' makes the first fall after enable a frame load even though p already reads 0.
  assign load     = fall & (~started | (p == P_LAST));
  assign p_next   = load ? '0 : p + 1'b1;
  assign lr_next  = STEREO ? (p_next >= P_SLOT) : (p_next == '0);

  always_comb begin
    src   = buf_full ? buf_dat : last_dat;
    frame = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      frame[N-1-c*SLOT_W -: DATA_W] = src[IW-1-c*DATA_W -: DATA_W];
    end
`ifdef I2S_UNDERRUN_MUTE_EN
    if (!buf_full) frame = '0;
`else
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mck_cnt   <= '0;
      sck_cnt   <= '0;
      mck       <= 1'b0;
      sck       <= 1'b0;
      p         <= '0;
      started   <= 1'b0;
      sr        <= '0;
      lr        <= 1'b0;
      d         <= 1'b0;
      frame_stb <= 1'b0;
    end else if (!enable) begin
      mck_cnt   <= '0;
      sck_cnt   <= '0;
      mck       <= 1'b0;
      sck       <= 1'b0;
      p         <= '0;
      started   <= 1'b0;
      sr        <= '0;
      lr        <= 1'b0;
      d         <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      if (mck_cnt == MCK_LAST) begin
        mck_cnt <= '0;
        mck     <= ~mck;
      end else begin
        mck_cnt <= mck_cnt + 1'b1;
      end
      if (sck_cnt == SCK_LAST) begin
        sck_cnt <= '0;
        sck     <= ~sck;
      end else begin
        sck_cnt <= sck_cnt + 1'b1;
      end
      frame_stb <= load;
      // The MSB still holds the previous frame's last bit when the reload happens.
      if (fall) begin
        p       <= p_next;
        started <= 1'b1;
        d       <= sr[N-1];
        lr      <= lr_next;
        sr      <= load ? frame : (sr << 1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_dat  <= '0;
      last_dat <= '0;
      buf_full <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (load && buf_full) begin
        last_dat <= buf_dat;
        buf_full <= 1'b0;
      end else if (take) begin
        buf_dat  <= in_data;
        buf_full <= 1'b1;
      end
      if (load && !buf_full) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: a stereo instance and a 4-channel TDM instance checked every cycle against a timing/content model.
module tb_i2s_tdm_tx;

  logic clock;
  logic reset;
  logic en   [2];
  logic vld  [2];
  logic clr  [2];
  logic [255:0] din [2];
  logic mck_o [2];
  logic sck_o [2];
  logic lr_o  [2];
  logic d_o   [2];
  logic stb_o [2];
  logic und_o [2];
  logic rdy_o [2];

  int cfg_dw [2] = '{16, 24};
  int cfg_sw [2] = '{16, 32};
  int cfg_ch [2] = '{2, 4};
  int cfg_mh [2] = '{1, 1};
  int cfg_sh [2] = '{2, 1};

  int n_tests = 0;
  int n_fail  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  i2s_tdm_tx u_st (
    .clock(clock), .reset(reset), .enable(en[0]),
    .in_data(din[0][31:0]), .in_valid(vld[0]), .in_ready(rdy_o[0]),
    .mck(mck_o[0]), .sck(sck_o[0]), .lr(lr_o[0]), .d(d_o[0]),
    .frame_stb(stb_o[0]), .underrun(und_o[0]), .underrun_clr(clr[0])
  );

  i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .CHANNELS(4), .MCK_HALF(1), .SCK_HALF(1)) u_tdm (
    .clock(clock), .reset(reset), .enable(en[1]),
    .in_data(din[1][95:0]), .in_valid(vld[1]), .in_ready(rdy_o[1]),
    .mck(mck_o[1]), .sck(sck_o[1]), .lr(lr_o[1]), .d(d_o[1]),
    .frame_stb(stb_o[1]), .underrun(und_o[1]), .underrun_clr(clr[1])
  );

  // Model state: enabled-edge count, buffer, last frame, current/previous serial frame (first bit at index N-1).
  int           m_t     [2];
  logic         m_full  [2];
  logic         m_under [2];
  logic         m_stb   [2];
  logic [255:0] m_buf   [2];
  logic [255:0] m_last  [2];
  logic [255:0] m_cur   [2];
  logic [255:0] m_prev  [2];

  function automatic logic [255:0] to_s(int i, logic [255:0] x);
    logic [255:0] s;
    logic [255:0] smp;
    int n;
    n = cfg_ch[i] * cfg_sw[i];
    s = '0;
    for (int c = 0; c < cfg_ch[i]; c++) begin
      smp = (x >> ((cfg_ch[i] - 1 - c) * cfg_dw[i])) & ((256'd1 << cfg_dw[i]) - 256'd1);
      s = s | (smp << (n - c * cfg_sw[i] - cfg_dw[i]));
    end
    return s;
  endfunction

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < 2; i++) begin : mdl
      logic of;
      logic ld;
      logic [255:0] ns;
      int h;
      int n;
      if (!reset) begin
        m_t[i] = 0; m_full[i] = 0; m_under[i] = 0; m_stb[i] = 0;
        m_buf[i] = '0; m_last[i] = '0; m_cur[i] = '0; m_prev[i] = '0;
      end else begin
        h  = cfg_sh[i];
        n  = cfg_ch[i] * cfg_sw[i];
        of = m_full[i];
        if (en[i]) m_t[i] = m_t[i] + 1;
        else begin
          m_t[i] = 0; m_cur[i] = '0; m_prev[i] = '0;
        end
        ld = en[i] && (m_t[i] >= 2 * h) && ((m_t[i] - 2 * h) % (2 * h * n) == 0);
        m_stb[i] = ld;
        if (ld) begin
          if (of) begin
            ns = to_s(i, m_buf[i]); m_last[i] = m_buf[i]; m_full[i] = 0;
          end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
            ns = '0;
`else
            ns = to_s(i, m_last[i]);
`endif
            m_under[i] = 1;
          end
          m_prev[i] = m_cur[i];
          m_cur[i]  = ns;
        end
        if (vld[i] && !of) begin
          m_buf[i] = din[i]; m_full[i] = 1;
        end
        if (clr[i] && !(ld && !of)) m_under[i] = 0;
      end
    end
  end

  // Expected {mck, sck, lr, d, frame_stb, underrun, in_ready} after the latest edge.
  function automatic logic [6:0] exp_vec(int i);
    int h, n, f, p;
    logic l, dd;
    h = cfg_sh[i];
    n = cfg_ch[i] * cfg_sw[i];
    f = m_t[i] / (2 * h);
    l = 0; dd = 0;
    if (f > 0) begin
      p  = (f - 1) % n;
      l  = (cfg_ch[i] == 2) ? (p >= cfg_sw[i]) : (p == 0);
      dd = (p == 0) ? m_prev[i][0] : m_cur[i][n - p];
    end
    return {1'((m_t[i] / cfg_mh[i]) % 2), 1'((m_t[i] / h) % 2), l, dd, m_stb[i], m_under[i], ~m_full[i]};
  endfunction

  function automatic logic [6:0] obs(int i);
    return {mck_o[i], sck_o[i], lr_o[i], d_o[i], stb_o[i], und_o[i], rdy_o[i]};
  endfunction

  function automatic logic load_next(int i);
    int h, n, t;
    h = cfg_sh[i];
    n = cfg_ch[i] * cfg_sw[i];
    t = m_t[i] + 1;
    return en[i] && (t >= 2 * h) && ((t - 2 * h) % (2 * h * n) == 0);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 0; vld[i] = 0; clr[i] = 0; din[i] = '0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== 7'b0000001) begin
        n_fail++; $display("FAIL reset_hold dut%0d got %b want %b", i, obs(i), 7'b0000001);
      end
    end
    reset = 1'b1;
    repeat (100) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs(i) !== 7'b0000001) begin
          n_fail++; $display("FAIL idle dut%0d got %b want %b", i, obs(i), 7'b0000001);
        end
      end
    end
  endtask

  task automatic test_stereo();
    logic bits [$];
    logic prev_sck;
    logic [31:0] w;
    int stbs;
    din[0] = 256'h A5F0_0F5A; vld[0] = 1;
    @(negedge clock);
    vld[0] = 0; en[0] = 1;
    prev_sck = 0; stbs = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clock);
      n_tests++;
      if (obs(0) !== exp_vec(0)) begin
        n_fail++; $display("FAIL stereo k=%0d got %b want %b", k, obs(0), exp_vec(0));
      end
      if (prev_sck && !sck_o[0]) bits.push_back(d_o[0]);
      prev_sck = sck_o[0];
      if (stb_o[0]) stbs++;
      vld[0] = (k == 10) || (k == 140);
      if (k == 10)  din[0] = 256'h 1234_5678;
      if (k == 140) din[0] = 256'h CAFE_BABE;
    end
    vld[0] = 0;
    n_tests++;
    if (stbs !== 3) begin
      n_fail++; $display("FAIL stereo_stb_count got %0d want 3", stbs);
    end
    n_tests++;
    if (bits.size() < 65) begin
      n_fail++; $display("FAIL stereo_fall_count got %0d want 65", bits.size());
    end else begin
      w = '0;
      for (int j = 1; j <= 32; j++) w = {w[30:0], bits[j]};
      n_tests++;
      if (w !== 32'hA5F0_0F5A) begin
        n_fail++; $display("FAIL stereo_frame0 got %h want a5f00f5a", w);
      end
      w = '0;
      for (int j = 33; j <= 64; j++) w = {w[30:0], bits[j]};
      if (w !== 32'h1234_5678) begin
        n_fail++; $display("FAIL stereo_frame1 got %h want 12345678", w);
      end
    end
  endtask

  task automatic test_back_to_back();
    vld[0] = 1;
    repeat (512) begin
      din[0] = {224'd0, 32'($urandom)};
      @(negedge clock);
      n_tests++;
      if (obs(0) !== exp_vec(0)) begin
        n_fail++; $display("FAIL backpressure got %b want %b", obs(0), exp_vec(0));
      end
    end
    vld[0] = 0;
  endtask

  task automatic test_underrun();
    repeat (384) begin
      @(negedge clock);
      n_tests++;
      if (obs(0) !== exp_vec(0)) begin
        n_fail++; $display("FAIL underrun_run got %b want %b", obs(0), exp_vec(0));
      end
    end
    n_tests++;
    if (und_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set got %b want 1", und_o[0]);
    end
    if (load_next(0)) @(negedge clock);
    clr[0] = 1;
    @(negedge clock);
    clr[0] = 0;
    n_tests++;
    if (und_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL underrun_clear got %b want 0", und_o[0]);
    end
    for (int k = 0; k < 200 && !load_next(0); k++) @(negedge clock);
    n_tests++;
    if (!load_next(0)) begin
      n_fail++; $display("FAIL underrun_wait_load got 0 want 1");
    end
    clr[0] = 1;
    @(negedge clock);
    clr[0] = 0;
    n_tests++;
    if (und_o[0] !== 1'b1 || stb_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set_priority got und=%b stb=%b want 1 1", und_o[0], stb_o[0]);
    end
    repeat (140) begin
      @(negedge clock);
      n_tests++;
      if (obs(0) !== exp_vec(0)) begin
        n_fail++; $display("FAIL underrun_after got %b want %b", obs(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_tdm();
    int lrs, stbs;
    lrs = 0; stbs = 0;
    en[1] = 1; vld[1] = 1;
    for (int k = 0; k < 800; k++) begin
      din[1] = {160'd0, 32'($urandom), 32'($urandom), 32'($urandom)};
      @(negedge clock);
      n_tests++;
      if (obs(1) !== exp_vec(1)) begin
        n_fail++; $display("FAIL tdm k=%0d got %b want %b", k, obs(1), exp_vec(1));
      end
      if (lr_o[1]) lrs++;
      if (stb_o[1]) stbs++;
    end
    n_tests++;
    if (lrs !== 8 || stbs !== 4) begin
      n_fail++; $display("FAIL tdm_sync got lr=%0d stb=%0d want 8 4", lrs, stbs);
    end
    en[1] = 0;
    repeat (50) begin
      @(negedge clock);
      n_tests++;
      if (obs(1) !== exp_vec(1)) begin
        n_fail++; $display("FAIL tdm_disabled got %b want %b", obs(1), exp_vec(1));
      end
    end
    en[1] = 1;
    repeat (300) begin
      din[1] = {160'd0, 32'($urandom), 32'($urandom), 32'($urandom)};
      @(negedge clock);
      n_tests++;
      if (obs(1) !== exp_vec(1)) begin
        n_fail++; $display("FAIL tdm_reenable got %b want %b", obs(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_async_reset();
    int f;
    for (int k = 0; k < 400; k++) begin
      f = m_t[1] / 2;
      if (f > 0 && (f - 1) % 128 == 40) break;
      @(negedge clock);
    end
    n_tests++;
    f = m_t[1] / 2;
    if (!(f > 0 && (f - 1) % 128 == 40)) begin
      n_fail++; $display("FAIL async_wait_p40 got f=%0d want p=40", f);
    end
    @(posedge clock);
    #1 reset = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs(i) !== 7'b0000001) begin
        n_fail++; $display("FAIL async_reset dut%0d got %b want %b", i, obs(i), 7'b0000001);
      end
    end
    @(negedge clock);
    reset = 1;
    repeat (300) begin
      din[1] = {160'd0, 32'($urandom), 32'($urandom), 32'($urandom)};
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL restart dut%0d got %b want %b", i, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_back_to_back();
    test_underrun();
    test_tdm();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised audio serial transmitter that replaces the fixed stereo I2S output stage feeding the board codec (TLV320AIC3254).
- Generates MCLK, BCLK and word/frame clock from the system clock.
- Supports stereo I2S (CHANNELS=2) and DSP/TDM framing (CHANNELS=4..8), with configurable sample and slot widths.
- Core audio sources deliver samples through a valid/ready handshake into a single holding buffer, with defined underrun behaviour.

Parameters:
DATA_W, 16, sample bits per channel (1..32)
SLOT_W, 16, BCLK periods per channel slot; must be ≥ DATA_W
CHANNELS, 2, channels per frame; even, 2..8; 2 selects I2S, >2 selects TDM
MCK_HALF, 1, system clocks per MCLK half-period (≥1)
SCK_HALF, 2, system clocks per BCLK half-period (≥1)

Ports:
clock  in  1  system clock (56 MHz in zx48)
reset  in  1  asynchronous, active-low
enable  in  1  run serializer; low holds dividers, counters and outputs at reset values
in_data  in  CHANNELS*DATA_W  frame samples; channel 0 in MSBs, two's complement
in_valid  in  1  in_data valid
in_ready  out  1  holding buffer empty
mck  out  1  codec master clock
sck  out  1  bit clock
lr  out  1  word select (I2S) / frame sync (TDM)
d  out  1  serial data
frame_stb  out  1  one-clock pulse at each frame load
underrun  out  1  sticky; set when a frame load finds the buffer empty
underrun_clr  in  1  synchronous clear of underrun; set has priority if both occur in the same cycle

Behaviour:
- Reset values (reset=0): mck=0, sck=0, lr=0, d=0, frame_stb=0, underrun=0, in_ready=1.
  - Internal state also resets: holding buffer empty, shift register 0, all counters 0, last-frame register 0.
- mck divider: counter 0..MCK_HALF-1; mck toggles on wrap. Free-running while enable=1, independent of sck.
- sck divider: counter 0..SCK_HALF-1; sck toggles on wrap.
  - A 1→0 toggle is a "fall event"; all serial outputs update only on fall events.
  - Codec samples on sck rising edge.
- Frame length N = CHANNELS*SLOT_W bits. Bit position counter p runs 0..N-1 and advances on each fall event, wrapping N-1→0.
- Serial stream S (N bits) per frame:
  - Slots concatenated channel 0 first.
  - Each slot is the DATA_W-bit sample MSB-first, zero-padded to SLOT_W on the LSB side.
- One-bit delay (both modes): at position p, d = S[p-1] of the current frame; at p=0, d = S[N-1] of the previous frame.
  - Implemented as an MSB-first shift register reloaded at the fall event that enters p=0, after its last bit has been driven.
- lr:
  - CHANNELS=2: lr=0 for p in 0..SLOT_W-1, lr=1 for p in SLOT_W..N-1.
  - CHANNELS>2: lr=1 only for p=0, else 0.
- Frame load (fall event entering p=0):
  - Buffer full: S ← buffer, last-frame ← buffer, buffer → empty, frame_stb=1 for that clock.
  - Buffer empty: S ← last-frame (repeat), underrun ← 1, frame_stb=1.
- Handshake:
  - in_ready = buffer empty.
  - Transfer when in_valid & in_ready: buffer captures in_data on that clock; in_ready drops next clock.
  - Transfer and frame load in the same clock: load uses the old buffer state (empty → underrun); the new data is captured into the buffer.
  - in_data is ignored when in_ready=0.
- enable=0:
  - Divider counters, p, mck, sck, lr and d are forced to reset values.
  - Buffer, last-frame and underrun are retained; the handshake still operates.
  - On re-enable, the first frame load occurs at the first fall event, which enters p=0 from the reset value of p.
- Asynchronous reset mid-frame: everything returns to reset values immediately; no partial output beyond the assertion.

Optional Feature:
I2S_UNDERRUN_MUTE_EN
- Defined: an underrun frame load sets S ← all zeros; last-frame is left unchanged.
- Undefined: an underrun repeats last-frame as described above.
- underrun flag behaviour is identical in both cases.

Test Plan:
1. Reset/idle: reset=0, then enable=0 for 100 clocks → mck=sck=lr=d=0, in_ready=1, underrun=0.
2. Stereo default: load ch0=0xA5F0, ch1=0x0F5A before enable.
   - 128 clocks per frame; lr low for 16 sck, then high for 16 sck.
   - d from p=1 is 1010010111110000, then 0000111101011010 shifted one bit.
   - frame_stb pulses once per 128 clocks.
3. Backpressure: hold in_valid=1 with changing data → in_ready is high for one transfer per frame, low until the next frame_stb; each frame carries the word accepted before it.
4. Underrun: stop in_valid after frame 0xA5F0/0x0F5A → next frame repeats the same bits, underrun=1. underrun_clr → 0. Simultaneous underrun and clear → 1.
5. TDM: CHANNELS=4, SLOT_W=32, DATA_W=24, SCK_HALF=1.
   - lr=1 for exactly one sck per 128 bits.
   - Channel k MSB appears at p=32k+1; the low 8 bits of each slot are 0.
6. Macro: with I2S_UNDERRUN_MUTE_EN, the underrun frame is all-zero d. Assert async reset at p=40 → outputs 0 within the same clock; restart is clean.
